// File: rtl/cluster_controller.sv
// Issue/dispatch controller for a cluster of NUM_PE PEs: fetches an aligned
// bundle, dispatches its longest hazard-free prefix, waits for completion.
// Latency: 3 cycles fetch-to-dispatch (FETCH, LOAD, CHECK).
// Backpressure: holds dispatch in WAIT until every issued lane reports complete.
// Ports:
//   clk, reset           rising-edge clock; asynchronous active-low reset
//   instruction_mem      fetched bundle, lane i at [XLEN*i +: XLEN]
//   PCsIM, InstReadEn    per-lane fetch address and read enable
//   PCinPE               PC of the instruction dispatched to PE i
//   instruction_outPE    instruction dispatched to PE i (0 = idle)
//   PCoutPE              next PC reported by each PE (used after control flow)
//   execution_complete   per-PE completion level, sampled in WAIT
module cluster_controller #(
  parameter int              NUM_PE   = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PE*XLEN-1:0] instruction_mem,
  output logic [NUM_PE*XLEN-1:0] PCsIM,
  output logic [NUM_PE-1:0]      InstReadEn,
  output logic [NUM_PE*XLEN-1:0] PCinPE,
  output logic [NUM_PE*XLEN-1:0] instruction_outPE,
  input  logic [NUM_PE*XLEN-1:0] PCoutPE,
  input  logic [NUM_PE-1:0]      execution_complete
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_CHECK    = 3'd3;
  localparam logic [2:0] ST_DISPATCH = 3'd4;
  localparam logic [2:0] ST_WAIT     = 3'd5;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [2:0]             state_q, state_d;
  logic [XLEN-1:0]        base_q, base_d;
  logic [NUM_PE*XLEN-1:0] bundle_q, bundle_d;
  logic [NUM_PE-1:0]      mask_q, mask_d;

  // Per-lane decode of the captured bundle. A register field only counts
  // when the opcode really uses it and it is not x0.
  logic [NUM_PE-1:0][4:0] rd_f, rs1_f, rs2_f;
  logic [NUM_PE-1:0]      wr_v, r1_v, r2_v, st_v, ld_v, cf_v;

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      logic [XLEN-1:0] ins;
      logic [6:0]      opc;
      ins      = bundle_q[i*XLEN +: XLEN];
      opc      = ins[6:0];
      rd_f[i]  = ins[11:7];
      rs1_f[i] = ins[19:15];
      rs2_f[i] = ins[24:20];
      wr_v[i]  = (opc == OP_REG || opc == OP_IMM || opc == OP_LOAD || opc == OP_LUI ||
                  opc == OP_AUIPC || opc == OP_JAL || opc == OP_JALR) && (rd_f[i] != 5'd0);
      r1_v[i]  = (opc == OP_REG || opc == OP_IMM || opc == OP_LOAD || opc == OP_STORE ||
                  opc == OP_BRANCH || opc == OP_JALR) && (rs1_f[i] != 5'd0);
      r2_v[i]  = (opc == OP_REG || opc == OP_STORE || opc == OP_BRANCH) && (rs2_f[i] != 5'd0);
      st_v[i]  = (opc == OP_STORE);
      ld_v[i]  = (opc == OP_LOAD);
      cf_v[i]  = (opc == OP_BRANCH || opc == OP_JAL || opc == OP_JALR);
    end
  end

  // Issue mask: contiguous prefix. A lane stops the prefix if it conflicts
  // with any older lane or if an older lane redirects control flow.
  logic [NUM_PE-1:0] mask_c;
  always_comb begin
    logic hz;
    logic cf_seen;
    mask_c    = '0;
    mask_c[0] = 1'b1;
    cf_seen   = cf_v[0];
    hz        = 1'b0;
    for (int j = 1; j < NUM_PE; j++) begin
      hz = 1'b0;
      for (int k = 0; k < j; k++) begin
        // RAW
        if (wr_v[k] && r1_v[j] && rs1_f[j] == rd_f[k]) hz = 1'b1;
        if (wr_v[k] && r2_v[j] && rs2_f[j] == rd_f[k]) hz = 1'b1;
        // WAW
        if (wr_v[k] && wr_v[j] && rd_f[j] == rd_f[k]) hz = 1'b1;
        // WAR
        if (wr_v[j] && r1_v[k] && rd_f[j] == rs1_f[k]) hz = 1'b1;
        if (wr_v[j] && r2_v[k] && rd_f[j] == rs2_f[k]) hz = 1'b1;
        // Memory ordering behind an older store
        if (st_v[k] && (ld_v[j] || st_v[j])) hz = 1'b1;
      end
      mask_c[j] = mask_c[j-1] & ~hz & ~cf_seen;
      cf_seen   = cf_seen | cf_v[j];
    end
  end

  // Next bundle base: redirect through the last issued lane if it is control
  // flow, otherwise step past the issued prefix (wraps modulo 2^XLEN).
  logic [XLEN-1:0] base_next;
  logic            all_done;
  always_comb begin
    logic [XLEN-1:0] cnt;
    logic            last_cf;
    logic [XLEN-1:0] last_pc;
    cnt     = '0;
    last_cf = 1'b0;
    last_pc = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (mask_q[i]) begin
        cnt     = cnt + XLEN'(1);
        last_cf = cf_v[i];
        last_pc = PCoutPE[i*XLEN +: XLEN];
      end
    end
    base_next = last_cf ? last_pc : (base_q + (cnt << 2));
    all_done  = ((execution_complete & mask_q) == mask_q);
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    bundle_d = bundle_q;
    mask_d   = mask_q;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_LOAD;
      ST_LOAD: begin
        bundle_d = instruction_mem;
        state_d  = ST_CHECK;
      end
      ST_CHECK: begin
        mask_d  = mask_c;
        state_d = ST_DISPATCH;
      end
      ST_DISPATCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (all_done) begin
          base_d  = base_next;
          state_d = ST_FETCH;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      base_q   <= RESET_PC;
      bundle_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      bundle_q <= bundle_d;
      mask_q   <= mask_d;
    end
  end

  // Outputs decode from registered state only, so an asynchronous reset
  // forces them to zero immediately and leaving WAIT clears dispatch.
  always_comb begin
    PCsIM             = '0;
    InstReadEn        = '0;
    PCinPE            = '0;
    instruction_outPE = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (state_q == ST_FETCH || state_q == ST_LOAD) begin
        PCsIM[i*XLEN +: XLEN] = base_q + XLEN'(4 * i);
        InstReadEn[i]         = 1'b1;
      end
      if ((state_q == ST_DISPATCH || state_q == ST_WAIT) && mask_q[i]) begin
        PCinPE[i*XLEN +: XLEN]            = base_q + XLEN'(4 * i);
        instruction_outPE[i*XLEN +: XLEN] = bundle_q[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: tb/tb_cluster_controller.sv
module tb_cluster_controller;

  logic         clk;
  logic         reset;
  logic [127:0] instruction_mem;
  logic [127:0] PCsIM;
  logic [3:0]   InstReadEn;
  logic [127:0] PCinPE;
  logic [127:0] instruction_outPE;
  logic [127:0] PCoutPE;
  logic [3:0]   execution_complete;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];

  cluster_controller #(.NUM_PE(4), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk                (clk),
    .reset              (reset),
    .instruction_mem    (instruction_mem),
    .PCsIM              (PCsIM),
    .InstReadEn         (InstReadEn),
    .PCinPE             (PCinPE),
    .instruction_outPE  (instruction_outPE),
    .PCoutPE            (PCoutPE),
    .execution_complete (execution_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: combinational word lookup per lane.
  for (genvar g = 0; g < 4; g++) begin : g_imem
    assign instruction_mem[g*32 +: 32] = mem[PCsIM[g*32+2 +: 6]];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pcsim"}, PCsIM, '0);
    chk({tag, "_rden"}, {124'd0, InstReadEn}, '0);
    chk({tag, "_pcin"}, PCinPE, '0);
    chk({tag, "_inst"}, instruction_outPE, '0);
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] base);
    logic [127:0] exp;
    for (int i = 0; i < 4; i++) exp[i*32 +: 32] = base + 32'(4 * i);
    chk({tag, "_fetch_pcsim"}, PCsIM, exp);
    chk({tag, "_fetch_rden"}, {124'd0, InstReadEn}, {124'd0, 4'hF});
  endtask

  // From FETCH: walk LOAD, CHECK, DISPATCH, and one WAIT cycle.
  task automatic run_bundle(input string tag, input logic [31:0] base,
                            input logic [3:0] mask, input logic [3:0] cmpl);
    logic [127:0] exp_pc, exp_in, exp_pcsim;
    for (int i = 0; i < 4; i++) begin
      exp_pcsim[i*32 +: 32] = base + 32'(4 * i);
      exp_pc[i*32 +: 32]    = mask[i] ? base + 32'(4 * i) : 32'h0;
      exp_in[i*32 +: 32]    = mask[i] ? mem[6'((base >> 2) + 32'(i))] : 32'h0;
    end
    step();  // LOAD
    chk({tag, "_load_pcsim"}, PCsIM, exp_pcsim);
    chk({tag, "_load_rden"}, {124'd0, InstReadEn}, {124'd0, 4'hF});
    step();  // CHECK
    chk({tag, "_check_rden"}, {124'd0, InstReadEn}, '0);
    chk({tag, "_check_pcin"}, PCinPE, '0);
    execution_complete = cmpl;
    step();  // DISPATCH
    chk({tag, "_disp_pcin"}, PCinPE, exp_pc);
    chk({tag, "_disp_inst"}, instruction_outPE, exp_in);
    step();  // WAIT
    chk({tag, "_wait_pcin"}, PCinPE, exp_pc);
    chk({tag, "_wait_inst"}, instruction_outPE, exp_in);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h001001B3;  // add x3,x0,x1
    mem[1]  = 32'h004102B3;  // add x5,x2,x4
    mem[2]  = 32'h00730433;  // add x8,x6,x7
    mem[3]  = 32'h00A485B3;  // add x11,x9,x10
    mem[4]  = 32'h00B002B3;  // add x5,x0,x11
    mem[5]  = 32'h00528333;  // add x6,x5,x5   (RAW on x5)
    mem[6]  = 32'h002083B3;  // add x7,x1,x2
    mem[7]  = 32'h004183B3;  // add x7,x3,x4   (WAW on x7)
    mem[8]  = 32'h00208063;  // beq x1,x2
    mem[16] = 32'h00112023;  // sw x1,0(x2)
    mem[17] = 32'h00022183;  // lw x3,0(x4)    (behind store)
    mem[18] = 32'h002082B3;  // add x5,x1,x2
    mem[19] = 32'h00730433;  // add x8,x6,x7
    mem[20] = 32'h00A485B3;  // add x11,x9,x10

    reset              = 1'b0;
    PCoutPE            = '0;
    execution_complete = 4'h0;

    // 1: reset and first fetch
    #12;
    chk_idle_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_idle_outputs("idle");
    step();
    chk_fetch("t1", 32'h0);

    // 2: independent bundle, all four issue
    run_bundle("t2", 32'h0, 4'b1111, 4'b1111);
    step();
    chk_fetch("t2n", 32'h10);

    // 3: RAW, only lane 0; non-issued complete bits ignored
    run_bundle("t3", 32'h10, 4'b0001, 4'b1101);
    step();
    chk_fetch("t3n", 32'h14);

    // 4: WAW between lanes 1 and 2
    run_bundle("t4", 32'h14, 4'b0011, 4'b0011);
    step();
    chk_fetch("t4n", 32'h1C);

    // 5: branch in lane 1 redirects to PCoutPE lane 1
    PCoutPE = {32'h0, 32'h0, 32'h40, 32'h99};
    run_bundle("t5", 32'h1C, 4'b0011, 4'b1011);
    step();
    chk_fetch("t5n", 32'h40);
    PCoutPE = '0;

    // 5b: store then load stops the prefix
    run_bundle("t5b", 32'h40, 4'b0001, 4'b0001);
    step();
    chk_fetch("t5bn", 32'h44);

    // 6: partial completion holds WAIT; reset aborts
    run_bundle("t6", 32'h44, 4'b1111, 4'b0111);
    step();
    step();
    chk("t6_hold_pcin", PCinPE, {32'h50, 32'h4C, 32'h48, 32'h44});
    chk("t6_hold_inst", instruction_outPE, {mem[20], mem[19], mem[18], mem[17]});
    chk("t6_hold_rden", {124'd0, InstReadEn}, '0);
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outputs("t6_rst");
    execution_complete = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_fetch("t6_refetch", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
